lpddr5_ca_decoder: RTL and testbench
====================================

# lpddr5_ca_decoder

Memory-side command decoder for the LPDDR5 CA bus: the receiving end of the command/address stream driven by the controller-side VIP driver. It takes the per-CK rising/falling CA phases from the DDR capture front-end, reassembles two-part commands (ACT-1/ACT-2), tracks per-bank open/idle state and open row, and emits one registered decoded-command pulse per accepted command plus protocol-error pulses. It feeds the memory model's read/write datapath and the scoreboard's protocol checker.

## Interface
- ACT_TMO, 8: max consecutive cs-low cycles allowed between ACT-1 and ACT-2 (range 1..255)
- ck_t  in  1  CK clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- cs  in  1  chip select for this cycle's CA phases
- ca_r  in  7  CA captured on CK rising edge
- ca_f  in  7  CA captured on CK falling edge (same CK cycle)
- cmd_valid  out  1  one-cycle decoded-command pulse
- cmd_type  out  3  1 ACT, 2 RD, 3 WR, 4 PRE, 5 REF
- cmd_bank  out  4  target bank
- cmd_row  out  14  ACT: new row; RD/WR: open row of bank; else 0
- cmd_col  out  6  RD/WR column; else 0
- cmd_all_bank  out  1  PRE/REF all-bank flag
- err_valid  out  1  one-cycle protocol-error pulse
- err_code  out  2  1 ILLEGAL, 2 ACT_SEQ, 3 BANK_STATE
- bank_active  out  16  per-bank open flag

## Operation
- Cycle ignored unless cs=1. Decode on ca_r[6:4]:
- 11x ACT-1: BA=ca_r[3:0], row_hi=ca_f[6:0]; stored as pending, no output.
- 10x ACT-2: BA=ca_r[3:0], row_lo=ca_f[6:0]; with matching pending -> ACT, row={row_hi,row_lo}.
- 011 WR16 / 010 RD16: BA=ca_r[3:0], col=ca_f[5:0].
- 001 PRE: all_bank=ca_r[3], BA=ca_f[3:0].
- 000: ca_r[3:0]=0000 NOP (no output); 0001 REF, all_bank=ca_f[4], BA=ca_f[3:0]; other -> ILLEGAL.
- ACT-2 without pending, or BA mismatch -> ACT_SEQ, pending cleared, nothing opened.
- Pending ACT-1 followed by any cs command other than ACT-2 -> ACT_SEQ for the pending, pending cleared; new command decoded normally in the same cycle (cmd_valid and err_valid may both assert).
- ACT-1 while pending -> ACT_SEQ; new ACT-1 replaces pending.
- Timeout: counter clears on ACT-1, increments each cs-low cycle while pending; on reaching ACT_TMO -> ACT_SEQ, pending cleared.
- ACT to open bank -> BANK_STATE, no state change, no cmd.
- RD/WR to idle bank -> BANK_STATE, no cmd.
- PRE: bank(s) -> idle; PRE to idle bank legal, cmd issued.
- REF per-bank requires bank idle; all-bank requires bank_active==0; else BANK_STATE, no cmd.
- Priority on one cycle: errors do not block bank-state update of a legal command.

## Timing
- All outputs registered: response one cycle after the sampled cs cycle.
- ACT output one cycle after ACT-2 cycle; bank_active/open row update visible same cycle as cmd_valid.
- Timeout error one cycle after the ACT_TMO-th idle cycle.
- Reset: all outputs 0, bank_active 0, open rows 0, pending and counter cleared; reset during a pending ACT discards it silently.
- No backpressure; a command may be accepted every cycle.

## Structure
- Package lpddr5_cmd_pkg: cmd_type_e, err_code_e, opcode field positions, ROW_W=14, COL_W=6, NUM_BANKS=16.
- Sub-module lpddr5_bank_tracker: bank_active vector, 16x14 open-row array, open/close/all-close ports, lookup by bank.
- Top: decode, ACT-1 pending register, timeout counter, output registers.

## Test plan
- ACT-1 (ca_r=1100011, ca_f=7'h55) then ACT-2 (ca_r=1000011, ca_f=7'h2A) -> cmd ACT, bank 3, row 14'h2AAA, bank_active=16'h0008.
- Then RD (ca_r=0100011, ca_f=7'h21) -> cmd RD, bank 3, row 14'h2AAA, col 6'h21.
- WR to idle bank 5 (ca_r=0110101) -> err_valid, code 3, no cmd_valid.
- ACT-1 bank 2 then 8 cs-low cycles -> err code 2 on next cycle; subsequent ACT-2 bank 2 -> err code 2 again, bank 2 stays idle.
- ACT-1 bank 2 then RD bank 3 -> same cycle err code 2 and cmd RD bank 3.
- PRE all (ca_r=0011000) -> cmd PRE all_bank=1, bank_active=0; REF all (ca_r=0000001, ca_f=7'h10) -> cmd REF; ACT-1 then reset -> ACT-2 after reset gives err code 2.

Source files
------------

// File: rtl/lpddr5_cmd_pkg.sv
// -----------------------------------------------------------------------------
// lpddr5_cmd_pkg
// Shared types and constants for the LPDDR5 CA-bus command decoder.
//   - cmd_type_e : decoded command codes driven on cmd_type
//   - err_code_e : protocol error codes driven on err_code
//   - op_class_e : internal classification of one CA rise/fall pair
//   - decode_op  : maps ca_r onto op_class_e
// -----------------------------------------------------------------------------
package lpddr5_cmd_pkg;

    localparam int unsigned NUM_BANKS  = 16;
    localparam int unsigned BANK_W     = 4;
    localparam int unsigned ROW_W      = 14;
    localparam int unsigned ROW_HALF_W = 7;
    localparam int unsigned COL_W      = 6;
    localparam int unsigned CA_W       = 7;

    // Opcode field in the rising-edge CA phase.
    localparam int unsigned OP_MSB = 6;
    localparam int unsigned OP_LSB = 4;

    typedef enum logic [2:0] {
        CmdNone = 3'd0,
        CmdAct  = 3'd1,
        CmdRd   = 3'd2,
        CmdWr   = 3'd3,
        CmdPre  = 3'd4,
        CmdRef  = 3'd5
    } cmd_type_e;

    typedef enum logic [1:0] {
        ErrNone      = 2'd0,
        ErrIllegal   = 2'd1,
        ErrActSeq    = 2'd2,
        ErrBankState = 2'd3
    } err_code_e;

    typedef enum logic [2:0] {
        OpNop,
        OpAct1,
        OpAct2,
        OpWr,
        OpRd,
        OpPre,
        OpRef,
        OpIllegal
    } op_class_e;

    function automatic op_class_e decode_op(input logic [CA_W-1:0] ca);
        op_class_e op;
        op = OpIllegal;
        casez (ca[OP_MSB:OP_LSB])
            3'b11?:  op = OpAct1;
            3'b10?:  op = OpAct2;
            3'b011:  op = OpWr;
            3'b010:  op = OpRd;
            3'b001:  op = OpPre;
            default: begin
                // 000 group is sub-decoded by the low nibble.
                if (ca[3:0] == 4'b0000) begin
                    op = OpNop;
                end else if (ca[3:0] == 4'b0001) begin
                    op = OpRef;
                end else begin
                    op = OpIllegal;
                end
            end
        endcase
        return op;
    endfunction

endpackage

// File: rtl/lpddr5_bank_tracker.sv
// -----------------------------------------------------------------------------
// lpddr5_bank_tracker
// Per-bank open/idle flags and open-row storage.
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   open_en/bank/row     : mark a bank open and remember its row
//   close_en/bank        : mark one bank idle
//   close_all            : mark every bank idle
//   lookup_bank          : bank to inspect (combinational read)
//   lookup_active/row    : state of lookup_bank
//   bank_active          : per-bank open flags
// Updates land on the clock edge, so new state is visible alongside the
// decoder's registered command pulse.
// -----------------------------------------------------------------------------
module lpddr5_bank_tracker
    import lpddr5_cmd_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 open_en,
    input  logic [BANK_W-1:0]    open_bank,
    input  logic [ROW_W-1:0]     open_row,
    input  logic                 close_en,
    input  logic [BANK_W-1:0]    close_bank,
    input  logic                 close_all,
    input  logic [BANK_W-1:0]    lookup_bank,
    output logic                 lookup_active,
    output logic [ROW_W-1:0]     lookup_row,
    output logic [NUM_BANKS-1:0] bank_active
);

    logic [NUM_BANKS-1:0] active_q, active_d;
    logic [ROW_W-1:0]     row_q [NUM_BANKS];

    always_comb begin
        active_d = active_q;
        if (close_all) begin
            active_d = '0;
        end else if (close_en) begin
            active_d[close_bank] = 1'b0;
        end
        if (open_en) begin
            active_d[open_bank] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            active_q <= '0;
            for (int i = 0; i < NUM_BANKS; i++) begin
                row_q[i] <= '0;
            end
        end else begin
            active_q <= active_d;
            if (open_en) begin
                row_q[open_bank] <= open_row;
            end
        end
    end

    assign lookup_active = active_q[lookup_bank];
    assign lookup_row    = row_q[lookup_bank];
    assign bank_active   = active_q;

endmodule

// File: rtl/lpddr5_ca_decoder.sv
// -----------------------------------------------------------------------------
// lpddr5_ca_decoder
// Memory-side LPDDR5 CA-bus decoder. Reassembles ACT-1/ACT-2 pairs, checks
// bank state, and emits registered command and protocol-error pulses.
// Ports:
//   ck_t, reset    : CK (rising edge), synchronous active-high reset
//   cs             : chip select qualifying this cycle's CA phases
//   ca_r, ca_f     : CA captured on CK rising / falling edge
//   cmd_valid      : one-cycle decoded command pulse
//   cmd_type       : 1 ACT, 2 RD, 3 WR, 4 PRE, 5 REF
//   cmd_bank       : target bank
//   cmd_row        : ACT new row, RD/WR open row, else 0
//   cmd_col        : RD/WR column, else 0
//   cmd_all_bank   : PRE/REF all-bank flag
//   err_valid      : one-cycle protocol error pulse
//   err_code       : 1 ILLEGAL, 2 ACT_SEQ, 3 BANK_STATE
//   bank_active    : per-bank open flags
// Parameter ACT_TMO: cs-low cycles tolerated between ACT-1 and ACT-2.
// -----------------------------------------------------------------------------
module lpddr5_ca_decoder
    import lpddr5_cmd_pkg::*;
#(
    parameter int unsigned ACT_TMO = 8
) (
    input  logic                 ck_t,
    input  logic                 reset,
    input  logic                 cs,
    input  logic [CA_W-1:0]      ca_r,
    input  logic [CA_W-1:0]      ca_f,
    output logic                 cmd_valid,
    output logic [2:0]           cmd_type,
    output logic [BANK_W-1:0]    cmd_bank,
    output logic [ROW_W-1:0]     cmd_row,
    output logic [COL_W-1:0]     cmd_col,
    output logic                 cmd_all_bank,
    output logic                 err_valid,
    output logic [1:0]           err_code,
    output logic [NUM_BANKS-1:0] bank_active
);

    localparam logic [7:0] TMO_LIMIT = 8'(ACT_TMO);

    op_class_e           op;
    logic [BANK_W-1:0]   bank_r;
    logic [BANK_W-1:0]   bank_f;

    // ACT-1 pending state and inter-phase timeout.
    logic                  pend_q, pend_d;
    logic [BANK_W-1:0]     pend_bank_q, pend_bank_d;
    logic [ROW_HALF_W-1:0] pend_row_hi_q, pend_row_hi_d;
    logic [7:0]            tmo_cnt_q, tmo_cnt_d;

    // Next values for the registered outputs.
    logic              cmd_valid_d;
    cmd_type_e         cmd_type_d;
    logic [BANK_W-1:0] cmd_bank_d;
    logic [ROW_W-1:0]  cmd_row_d;
    logic [COL_W-1:0]  cmd_col_d;
    logic              cmd_all_bank_d;
    logic              err_valid_d;
    err_code_e         err_code_d;

    // Bank tracker interface.
    logic              trk_open_en;
    logic [BANK_W-1:0] trk_open_bank;
    logic [ROW_W-1:0]  trk_open_row;
    logic              trk_close_en;
    logic [BANK_W-1:0] trk_close_bank;
    logic              trk_close_all;
    logic [BANK_W-1:0] lookup_bank;
    logic              lookup_active;
    logic [ROW_W-1:0]  lookup_row;

    assign op     = decode_op(ca_r);
    assign bank_r = ca_r[BANK_W-1:0];
    assign bank_f = ca_f[BANK_W-1:0];

    // PRE and REF carry their bank in the falling phase; all others in rising.
    assign lookup_bank = ((op == OpPre) || (op == OpRef)) ? bank_f : bank_r;

    lpddr5_bank_tracker u_bank_tracker (
        .clk           (ck_t),
        .reset         (reset),
        .open_en       (trk_open_en),
        .open_bank     (trk_open_bank),
        .open_row      (trk_open_row),
        .close_en      (trk_close_en),
        .close_bank    (trk_close_bank),
        .close_all     (trk_close_all),
        .lookup_bank   (lookup_bank),
        .lookup_active (lookup_active),
        .lookup_row    (lookup_row),
        .bank_active   (bank_active)
    );

    always_comb begin
        pend_d         = pend_q;
        pend_bank_d    = pend_bank_q;
        pend_row_hi_d  = pend_row_hi_q;
        tmo_cnt_d      = tmo_cnt_q;

        cmd_valid_d    = 1'b0;
        cmd_type_d     = CmdNone;
        cmd_bank_d     = '0;
        cmd_row_d      = '0;
        cmd_col_d      = '0;
        cmd_all_bank_d = 1'b0;
        err_valid_d    = 1'b0;
        err_code_d     = ErrNone;

        trk_open_en    = 1'b0;
        trk_open_bank  = bank_r;
        trk_open_row   = {pend_row_hi_q, ca_f};
        trk_close_en   = 1'b0;
        trk_close_bank = bank_f;
        trk_close_all  = 1'b0;

        if (cs) begin
            // A pending ACT-1 is orphaned by any real command except ACT-2.
            // That error takes the single err_code slot; the new command is
            // still decoded and, if legal, still updates bank state.
            if (pend_q && (op != OpAct2) && (op != OpNop)) begin
                err_valid_d = 1'b1;
                err_code_d  = ErrActSeq;
                pend_d      = 1'b0;
            end

            case (op)
                OpAct1: begin
                    pend_d        = 1'b1;
                    pend_bank_d   = bank_r;
                    pend_row_hi_d = ca_f;
                    tmo_cnt_d     = '0;
                end
                OpAct2: begin
                    pend_d = 1'b0;
                    if (pend_q && (pend_bank_q == bank_r)) begin
                        if (lookup_active) begin
                            err_valid_d = 1'b1;
                            err_code_d  = ErrBankState;
                        end else begin
                            trk_open_en = 1'b1;
                            cmd_valid_d = 1'b1;
                            cmd_type_d  = CmdAct;
                            cmd_bank_d  = bank_r;
                            cmd_row_d   = {pend_row_hi_q, ca_f};
                        end
                    end else begin
                        err_valid_d = 1'b1;
                        err_code_d  = ErrActSeq;
                    end
                end
                OpRd, OpWr: begin
                    if (lookup_active) begin
                        cmd_valid_d = 1'b1;
                        cmd_type_d  = (op == OpRd) ? CmdRd : CmdWr;
                        cmd_bank_d  = bank_r;
                        cmd_row_d   = lookup_row;
                        cmd_col_d   = ca_f[COL_W-1:0];
                    end else if (!err_valid_d) begin
                        err_valid_d = 1'b1;
                        err_code_d  = ErrBankState;
                    end
                end
                OpPre: begin
                    // Precharging an idle bank is legal and still reported.
                    trk_close_en   = 1'b1;
                    trk_close_all  = ca_r[3];
                    cmd_valid_d    = 1'b1;
                    cmd_type_d     = CmdPre;
                    cmd_bank_d     = bank_f;
                    cmd_all_bank_d = ca_r[3];
                end
                OpRef: begin
                    if (ca_f[4] ? (bank_active == '0) : !lookup_active) begin
                        cmd_valid_d    = 1'b1;
                        cmd_type_d     = CmdRef;
                        cmd_bank_d     = bank_f;
                        cmd_all_bank_d = ca_f[4];
                    end else if (!err_valid_d) begin
                        err_valid_d = 1'b1;
                        err_code_d  = ErrBankState;
                    end
                end
                OpIllegal: begin
                    if (!err_valid_d) begin
                        err_valid_d = 1'b1;
                        err_code_d  = ErrIllegal;
                    end
                end
                default: begin
                    // NOP: no output, pending ACT-1 and its counter untouched.
                end
            endcase
        end else if (pend_q) begin
            tmo_cnt_d = tmo_cnt_q + 8'd1;
            if (tmo_cnt_d == TMO_LIMIT) begin
                err_valid_d = 1'b1;
                err_code_d  = ErrActSeq;
                pend_d      = 1'b0;
            end
        end
    end

    always_ff @(posedge ck_t) begin
        if (reset) begin
            pend_q        <= 1'b0;
            pend_bank_q   <= '0;
            pend_row_hi_q <= '0;
            tmo_cnt_q     <= '0;
            cmd_valid     <= 1'b0;
            cmd_type      <= '0;
            cmd_bank      <= '0;
            cmd_row       <= '0;
            cmd_col       <= '0;
            cmd_all_bank  <= 1'b0;
            err_valid     <= 1'b0;
            err_code      <= '0;
        end else begin
            pend_q        <= pend_d;
            pend_bank_q   <= pend_bank_d;
            pend_row_hi_q <= pend_row_hi_d;
            tmo_cnt_q     <= tmo_cnt_d;
            cmd_valid     <= cmd_valid_d;
            cmd_type      <= cmd_type_d;
            cmd_bank      <= cmd_bank_d;
            cmd_row       <= cmd_row_d;
            cmd_col       <= cmd_col_d;
            cmd_all_bank  <= cmd_all_bank_d;
            err_valid     <= err_valid_d;
            err_code      <= err_code_d;
        end
    end

endmodule

// File: tb/tb_lpddr5_ca_decoder.sv
// -----------------------------------------------------------------------------
// tb_lpddr5_ca_decoder
// Directed bench: each step drives one CK cycle of CA, queues the expected
// registered response, and compares every output one cycle later.
// -----------------------------------------------------------------------------
module tb_lpddr5_ca_decoder;

    typedef struct {
        logic        cv;
        logic [2:0]  ct;
        logic [3:0]  cb;
        logic [13:0] cr;
        logic [5:0]  cc;
        logic        ca;
        logic        ev;
        logic [1:0]  ec;
        logic [15:0] ba;
        string       tag;
    } exp_t;

    logic        ck_t;
    logic        reset;
    logic        cs;
    logic [6:0]  ca_r;
    logic [6:0]  ca_f;
    logic        cmd_valid;
    logic [2:0]  cmd_type;
    logic [3:0]  cmd_bank;
    logic [13:0] cmd_row;
    logic [5:0]  cmd_col;
    logic        cmd_all_bank;
    logic        err_valid;
    logic [1:0]  err_code;
    logic [15:0] bank_active;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];

    lpddr5_ca_decoder #(.ACT_TMO(8)) dut (
        .ck_t         (ck_t),
        .reset        (reset),
        .cs           (cs),
        .ca_r         (ca_r),
        .ca_f         (ca_f),
        .cmd_valid    (cmd_valid),
        .cmd_type     (cmd_type),
        .cmd_bank     (cmd_bank),
        .cmd_row      (cmd_row),
        .cmd_col      (cmd_col),
        .cmd_all_bank (cmd_all_bank),
        .err_valid    (err_valid),
        .err_code     (err_code),
        .bank_active  (bank_active)
    );

    initial ck_t = 1'b0;
    always #5 ck_t = ~ck_t;

    localparam logic [2:0] ACT = 3'd1, RD = 3'd2, WR = 3'd3, PRE = 3'd4, REF = 3'd5;

    function automatic exp_t mk(input logic cv, input logic [2:0] ct, input logic [3:0] cb,
                                input logic [13:0] cr, input logic [5:0] cc, input logic ca,
                                input logic ev, input logic [1:0] ec, input logic [15:0] ba);
        exp_t e;
        e.cv = cv; e.ct = ct; e.cb = cb; e.cr = cr; e.cc = cc; e.ca = ca;
        e.ev = ev; e.ec = ec; e.ba = ba; e.tag = "";
        return e;
    endfunction

    function automatic exp_t quiet(input logic [15:0] ba);
        return mk(1'b0, 3'd0, 4'd0, 14'd0, 6'd0, 1'b0, 1'b0, 2'd0, ba);
    endfunction

    function automatic exp_t err(input logic [1:0] ec, input logic [15:0] ba);
        return mk(1'b0, 3'd0, 4'd0, 14'd0, 6'd0, 1'b0, 1'b1, ec, ba);
    endfunction

    function automatic exp_t cmd(input logic [2:0] ct, input logic [3:0] cb,
                                 input logic [13:0] cr, input logic [5:0] cc, input logic ca,
                                 input logic [15:0] ba);
        return mk(1'b1, ct, cb, cr, cc, ca, 1'b0, 2'd0, ba);
    endfunction

    task automatic check(input string tag, input string field, input logic [31:0] obs,
                         input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tag, field, obs, expv);
        end
    endtask

    task automatic compare_head();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard observed=empty expected=entry");
            return;
        end
        e = sb.pop_front();
        check(e.tag, "cmd_valid", 32'(cmd_valid), 32'(e.cv));
        check(e.tag, "cmd_type", 32'(cmd_type), 32'(e.ct));
        check(e.tag, "cmd_bank", 32'(cmd_bank), 32'(e.cb));
        check(e.tag, "cmd_row", 32'(cmd_row), 32'(e.cr));
        check(e.tag, "cmd_col", 32'(cmd_col), 32'(e.cc));
        check(e.tag, "cmd_all_bank", 32'(cmd_all_bank), 32'(e.ca));
        check(e.tag, "err_valid", 32'(err_valid), 32'(e.ev));
        check(e.tag, "err_code", 32'(err_code), 32'(e.ec));
        check(e.tag, "bank_active", 32'(bank_active), 32'(e.ba));
    endtask

    // One CK cycle: drive CA, queue expectation, compare just after the edge.
    task automatic step(input string tag, input logic c, input logic [6:0] r,
                        input logic [6:0] f, input exp_t e);
        exp_t q;
        q = e;
        q.tag = tag;
        cs = c;
        ca_r = r;
        ca_f = f;
        sb.push_back(q);
        @(posedge ck_t);
        #1;
        compare_head();
    endtask

    initial begin
        reset = 1'b1;
        cs    = 1'b0;
        ca_r  = '0;
        ca_f  = '0;
        #1;

        step("reset0", 1'b0, 7'h00, 7'h00, quiet(16'h0000));
        step("reset1", 1'b1, 7'b1100011, 7'h55, quiet(16'h0000));
        reset = 1'b0;

        // Basic ACT / RD / WR on bank 3.
        step("act1_b3", 1'b1, 7'b1100011, 7'h55, quiet(16'h0000));
        step("act2_b3", 1'b1, 7'b1000011, 7'h2A, cmd(ACT, 4'd3, 14'h2AAA, 6'h00, 1'b0, 16'h0008));
        step("rd_b3", 1'b1, 7'b0100011, 7'h21, cmd(RD, 4'd3, 14'h2AAA, 6'h21, 1'b0, 16'h0008));
        step("wr_idle_b5", 1'b1, 7'b0110101, 7'h05, err(2'd3, 16'h0008));
        step("wr_b3", 1'b1, 7'b0110011, 7'h7F, cmd(WR, 4'd3, 14'h2AAA, 6'h3F, 1'b0, 16'h0008));

        // ACT to an already-open bank is rejected and leaves its row alone.
        step("act1_open_b3", 1'b1, 7'b1100011, 7'h01, quiet(16'h0008));
        step("act2_open_b3", 1'b1, 7'b1000011, 7'h02, err(2'd3, 16'h0008));
        step("rd_b3_row_kept", 1'b1, 7'b0100011, 7'h00, cmd(RD, 4'd3, 14'h2AAA, 6'h00, 1'b0, 16'h0008));

        // Timeout: 8 cs-low cycles after ACT-1, then a late ACT-2.
        step("act1_b2_tmo", 1'b1, 7'b1100010, 7'h11, quiet(16'h0008));
        for (int i = 1; i < 8; i++) begin
            step("tmo_idle", 1'b0, 7'h00, 7'h00, quiet(16'h0008));
        end
        step("tmo_expire", 1'b0, 7'h00, 7'h00, err(2'd2, 16'h0008));
        step("act2_after_tmo", 1'b1, 7'b1000010, 7'h22, err(2'd2, 16'h0008));

        // Orphaned ACT-1 plus a legal RD in the same cycle.
        step("act1_b2_orph", 1'b1, 7'b1100010, 7'h11, quiet(16'h0008));
        step("orph_rd_b3", 1'b1, 7'b0100011, 7'h04,
             mk(1'b1, RD, 4'd3, 14'h2AAA, 6'h04, 1'b0, 1'b1, 2'd2, 16'h0008));

        // Second bank, row lookup is per bank.
        step("act1_b1", 1'b1, 7'b1100001, 7'h7F, quiet(16'h0008));
        step("act2_b1", 1'b1, 7'b1000001, 7'h00, cmd(ACT, 4'd1, 14'h3F80, 6'h00, 1'b0, 16'h000A));
        step("rd_b1", 1'b1, 7'b0100001, 7'h15, cmd(RD, 4'd1, 14'h3F80, 6'h15, 1'b0, 16'h000A));

        // ACT-2 bank mismatch, then ACT-2 with nothing pending.
        step("act1_b1_mm", 1'b1, 7'b1100001, 7'h00, quiet(16'h000A));
        step("act2_b4_mm", 1'b1, 7'b1000100, 7'h00, err(2'd2, 16'h000A));
        step("act2_b4_nopend", 1'b1, 7'b1000100, 7'h00, err(2'd2, 16'h000A));

        // ACT-1 replaced by a second ACT-1.
        step("act1_b7", 1'b1, 7'b1100111, 7'h33, quiet(16'h000A));
        step("act1_b6_repl", 1'b1, 7'b1100110, 7'h00, err(2'd2, 16'h000A));
        step("act2_b6", 1'b1, 7'b1000110, 7'h05, cmd(ACT, 4'd6, 14'h0005, 6'h00, 1'b0, 16'h004A));

        // REF bank-state rules.
        step("ref_open_b6", 1'b1, 7'b0000001, 7'h06, err(2'd3, 16'h004A));
        step("ref_idle_b0", 1'b1, 7'b0000001, 7'h00, cmd(REF, 4'd0, 14'h0, 6'h00, 1'b0, 16'h004A));
        step("ref_all_busy", 1'b1, 7'b0000001, 7'h10, err(2'd3, 16'h004A));

        // PRE per bank, PRE to an idle bank, illegal and NOP encodings.
        step("pre_b1", 1'b1, 7'b0010000, 7'h01, cmd(PRE, 4'd1, 14'h0, 6'h00, 1'b0, 16'h0048));
        step("pre_idle_b9", 1'b1, 7'b0010000, 7'h09, cmd(PRE, 4'd9, 14'h0, 6'h00, 1'b0, 16'h0048));
        step("illegal", 1'b1, 7'b0000010, 7'h00, err(2'd1, 16'h0048));
        step("nop", 1'b1, 7'b0000000, 7'h7F, quiet(16'h0048));

        // PRE all, then RD is rejected and REF all is accepted.
        step("pre_all", 1'b1, 7'b0011000, 7'h00, cmd(PRE, 4'd0, 14'h0, 6'h00, 1'b1, 16'h0000));
        step("rd_after_pre", 1'b1, 7'b0100011, 7'h00, err(2'd3, 16'h0000));
        step("ref_all", 1'b1, 7'b0000001, 7'h10, cmd(REF, 4'd0, 14'h0, 6'h00, 1'b1, 16'h0000));

        // CA is ignored while cs is low.
        step("cs_low_act1", 1'b0, 7'b1100011, 7'h12, quiet(16'h0000));
        step("act2_no_pend", 1'b1, 7'b1000011, 7'h34, err(2'd2, 16'h0000));

        // Reset clears open banks and silently discards a pending ACT-1.
        step("act1_b5", 1'b1, 7'b1100101, 7'h0F, quiet(16'h0000));
        step("act2_b5", 1'b1, 7'b1000101, 7'h01, cmd(ACT, 4'd5, 14'h0781, 6'h00, 1'b0, 16'h0020));
        step("act1_b4_pre_rst", 1'b1, 7'b1100100, 7'h0A, quiet(16'h0020));
        reset = 1'b1;
        step("reset_mid", 1'b0, 7'h00, 7'h00, quiet(16'h0000));
        reset = 1'b0;
        step("act2_b4_post_rst", 1'b1, 7'b1000100, 7'h0B, err(2'd2, 16'h0000));
        step("rd_b5_post_rst", 1'b1, 7'b0100101, 7'h00, err(2'd3, 16'h0000));
        step("idle_end", 1'b0, 7'h00, 7'h00, quiet(16'h0000));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
